// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, cause codes and mux selects.
package mc_ctrl_pkg;

    localparam int unsigned CtrlStateW = 5;

    typedef enum logic [CtrlStateW-1:0] {
        StFetch   = 5'd0,
        StDecode  = 5'd1,
        StCExec   = 5'd2,
        StCWrite  = 5'd3,
        StBranch  = 5'd4,
        StJump    = 5'd5,
        StJal1    = 5'd6,
        StJal2    = 5'd7,
        StJumpReg = 5'd8,
        StLui     = 5'd9,
        StLli     = 5'd10,
        StLtr     = 5'd11,
        StCtr     = 5'd12,
        StLw1     = 5'd13,
        StLw2     = 5'd14,
        StSw      = 5'd15,
        StSyscall = 5'd16,
        StTrap    = 5'd17,
        StIrq     = 5'd18
    } ctrlState_e;

    typedef enum logic [1:0] {
        CauseSyscall = 2'd0,
        CauseIllegal = 2'd1,
        CauseBusErr  = 2'd2,
        CauseIrq     = 2'd3
    } trapCause_e;

    localparam int unsigned OpAlu          = 0;
    localparam int unsigned OpBeq          = 1;
    localparam int unsigned OpBne          = 2;
    localparam int unsigned OpJump         = 3;
    localparam int unsigned OpJal          = 4;
    localparam int unsigned OpJr           = 5;
    localparam int unsigned OpLui          = 6;
    localparam int unsigned OpLli          = 7;
    localparam int unsigned OpLtr          = 8;
    localparam int unsigned OpCtr          = 9;
    localparam int unsigned OpLw           = 10;
    localparam int unsigned OpSw           = 11;
    localparam int unsigned OpSyscall      = 12;
    localparam int unsigned OpTrap         = 13;
    localparam int unsigned OpFirstIllegal = 14;

    localparam logic [2:0] PcSrcAlu    = 3'd0;
    localparam logic [2:0] PcSrcAluOut = 3'd1;
    localparam logic [2:0] PcSrcReg    = 3'd2;
    localparam logic [2:0] PcSrcJump   = 3'd3;
    localparam logic [2:0] PcSrcVector = 3'd4;

    localparam logic [2:0] WsAlu   = 3'd0;
    localparam logic [2:0] WsCr    = 3'd1;
    localparam logic [2:0] WsMem   = 3'd2;
    localparam logic [2:0] WsUpper = 3'd3;
    localparam logic [2:0] WsLower = 3'd4;
    localparam logic [2:0] WsPc    = 3'd5;
    localparam logic [2:0] WsLtr   = 3'd6;

    localparam logic [1:0] WdRt   = 2'd0;
    localparam logic [1:0] WdRd   = 2'd1;
    localparam logic [1:0] WdLink = 2'd2;

    localparam logic [2:0] SrcBReg    = 3'd0;
    localparam logic [2:0] SrcBTwo    = 3'd1;
    localparam logic [2:0] SrcBImm    = 3'd2;
    localparam logic [2:0] SrcBBranch = 3'd4;

    localparam logic [1:0] AluAdd   = 2'd0;
    localparam logic [1:0] AluSub   = 2'd1;
    localparam logic [1:0] AluFunct = 2'd2;

    function automatic logic isMemState(ctrlState_e s);
        return (s == StFetch) || (s == StLw1) || (s == StSw);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the 16-bit datapath (slave).
interface mc_control_fsm_if #(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned STATE_W  = 5,
    parameter int unsigned CAUSE_W  = 2
);
    logic [OPCODE_W-1:0] Opcode;
    logic                MemReady;
    logic                IrqReq;
    logic [2:0]          PCSrc;
    logic                PCWrite;
    logic                isBranch;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic                CRWrite;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [1:0]          WriteDest;
    logic [2:0]          WriteSrc;
    logic [2:0]          ALUSrcB;
    logic [1:0]          ALUOp;
    logic [CAUSE_W-1:0]  IntCause;
    logic                CauseWrite;
    logic                EPCWrite;
    logic                IrqAck;
    logic [STATE_W-1:0]  current_state;

    modport master (
        input  Opcode, MemReady, IrqReq,
        output PCSrc, PCWrite, isBranch, IorD, MemRead, MemWrite, IRWrite, CRWrite, RegWrite,
               ALUSrcA, WriteDest, WriteSrc, ALUSrcB, ALUOp, IntCause, CauseWrite, EPCWrite,
               IrqAck, current_state
    );

    modport slave (
        output Opcode, MemReady, IrqReq,
        input  PCSrc, PCWrite, isBranch, IorD, MemRead, MemWrite, IRWrite, CRWrite, RegWrite,
               ALUSrcA, WriteDest, WriteSrc, ALUSrcB, ALUOp, IntCause, CauseWrite, EPCWrite,
               IrqAck, current_state
    );
endinterface

// File: rtl/mc_mem_wait_timer.sv
// Memory wait-state counter; flags a bus timeout after MEM_TIMEOUT stalled cycles (0 disables).
module mc_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic CLK,
    input  logic Reset,
    input  logic memState,
    input  logic memReady,
    output logic timeout
);
    localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CntW-1:0] countQ, countD;
    logic            stalled;

    always_comb begin
        stalled = memState && !memReady;
        timeout = (MEM_TIMEOUT != 0) && stalled && (countQ == CntW'(MEM_TIMEOUT));
        // Anything other than a plain stall (ready, timeout exit, non-memory state) clears.
        countD  = '0;
        if (stalled && !timeout && (MEM_TIMEOUT != 0)) begin
            countD = countQ + CntW'(1);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            countQ <= '0;
        end else begin
            countQ <= countD;
        end
    end
endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM with memory wait states, trap causes and vectored trap entry.
// Define CTRL_IRQ_EN to enable interrupt entry at instruction boundaries.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned STATE_W     = 5,
    parameter int unsigned CAUSE_W     = 2,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic               CLK,
    input logic               Reset,
    mc_control_fsm_if.master  bus
);
    ctrlState_e stateQ, stateD;
    trapCause_e causeQ, causeD;
    logic       memTimeout;

    mc_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .CLK      (CLK),
        .Reset    (Reset),
        .memState (isMemState(stateQ)),
        .memReady (bus.MemReady),
        .timeout  (memTimeout)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stateQ <= StFetch;
            causeQ <= CauseSyscall;
        end else begin
            stateQ <= stateD;
            causeQ <= causeD;
        end
    end

    always_comb begin
        stateD = stateQ;
        causeD = causeQ;
        case (stateQ)
            StFetch, StLw1, StSw: begin
                if (bus.MemReady) begin
                    stateD = (stateQ == StFetch) ? StDecode :
                             (stateQ == StLw1)   ? StLw2    : StFetch;
                end else if (memTimeout) begin
                    stateD = StTrap;
                    causeD = CauseBusErr;
                end
            end
            StDecode: begin
                case (32'(bus.Opcode))
                    OpAlu:          stateD = StCExec;
                    OpBeq, OpBne:   stateD = StBranch;
                    OpJump:         stateD = StJump;
                    OpJal:          stateD = StJal1;
                    OpJr:           stateD = StJumpReg;
                    OpLui:          stateD = StLui;
                    OpLli:          stateD = StLli;
                    OpLtr:          stateD = StLtr;
                    OpCtr:          stateD = StCtr;
                    OpLw:           stateD = StLw1;
                    OpSw:           stateD = StSw;
                    OpSyscall:      stateD = StSyscall;
                    OpTrap: begin
                        stateD = StTrap;
                        causeD = CauseSyscall;
                    end
                    default: begin
                        stateD = StTrap;
                        causeD = CauseIllegal;
                    end
                endcase
            end
            StCExec:  stateD = StCWrite;
            StJal1:   stateD = StJal2;
            StLw2:    stateD = StFetch;
            default:  stateD = StFetch;
        endcase
`ifdef CTRL_IRQ_EN
        // Interrupts are only taken at a genuine instruction boundary, never out of a trap entry.
        if (bus.IrqReq && (stateD == StFetch) && (stateQ != StFetch) &&
            (stateQ != StTrap) && (stateQ != StIrq)) begin
            stateD = StIrq;
            causeD = CauseIrq;
        end
`endif
    end

    always_comb begin
        bus.PCSrc      = PcSrcAlu;
        bus.PCWrite    = 1'b0;
        bus.isBranch   = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.CRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.WriteDest  = WdRt;
        bus.WriteSrc   = WsAlu;
        bus.ALUSrcB    = SrcBTwo;
        bus.ALUOp      = AluAdd;
        bus.CauseWrite = 1'b0;
        bus.EPCWrite   = 1'b0;
        bus.IrqAck     = 1'b0;
        case (stateQ)
            StFetch: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = bus.MemReady;
                bus.PCWrite = bus.MemReady;
            end
            StDecode:  bus.ALUSrcB = SrcBBranch;
            StCExec: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SrcBReg;
                bus.ALUOp   = AluFunct;
            end
            StCWrite: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SrcBReg;
                bus.ALUOp     = AluFunct;
                bus.RegWrite  = 1'b1;
                bus.CRWrite   = 1'b1;
                bus.WriteDest = WdRd;
            end
            StBranch: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUSrcB  = SrcBReg;
                bus.ALUOp    = AluSub;
                bus.isBranch = 1'b1;
                bus.PCSrc    = PcSrcAluOut;
            end
            StJump, StJal2: begin
                bus.PCWrite = 1'b1;
                bus.PCSrc   = PcSrcJump;
            end
            StJal1: begin
                bus.RegWrite  = 1'b1;
                bus.WriteDest = WdLink;
                bus.WriteSrc  = WsPc;
            end
            StJumpReg: begin
                bus.ALUSrcA = 1'b1;
                bus.PCWrite = 1'b1;
                bus.PCSrc   = PcSrcReg;
            end
            StLui: begin
                bus.RegWrite = 1'b1;
                bus.WriteSrc = WsUpper;
            end
            StLli: begin
                bus.RegWrite = 1'b1;
                bus.WriteSrc = WsLower;
            end
            StLtr: begin
                bus.RegWrite = 1'b1;
                bus.WriteSrc = WsLtr;
            end
            StCtr: begin
                bus.ALUSrcA  = 1'b1;
                bus.CRWrite  = 1'b1;
                bus.WriteSrc = WsCr;
            end
            StLw1: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SrcBImm;
            end
            StLw2: begin
                bus.RegWrite = 1'b1;
                bus.WriteSrc = WsMem;
            end
            StSw: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                bus.ALUSrcA  = 1'b1;
                bus.ALUSrcB  = SrcBImm;
            end
            StSyscall:  bus.PCWrite = 1'b1;
            StTrap, StIrq: begin
                bus.EPCWrite   = 1'b1;
                bus.CauseWrite = 1'b1;
                bus.PCWrite    = 1'b1;
                bus.PCSrc      = PcSrcVector;
`ifdef CTRL_IRQ_EN
                bus.IrqAck     = (stateQ == StIrq);
`endif
            end
            default: ;
        endcase
        // State is already FETCH during reset; only the strobes need suppressing.
        if (Reset) begin
            bus.PCWrite    = 1'b0;
            bus.isBranch   = 1'b0;
            bus.MemRead    = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.CRWrite    = 1'b0;
            bus.RegWrite   = 1'b0;
            bus.CauseWrite = 1'b0;
            bus.EPCWrite   = 1'b0;
            bus.IrqAck     = 1'b0;
        end
    end

    assign bus.IntCause      = CAUSE_W'(causeQ);
    assign bus.current_state = STATE_W'(stateQ);
endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized instruction-level bench for mc_control_fsm with a queue-based expected-cycle model.
module tb_mc_control_fsm;
    localparam int TO = 15;

    localparam int SFetch = 0, SDecode = 1, SCExec = 2, SCWrite = 3, SBranch = 4, SJump = 5;
    localparam int SJal1 = 6, SJal2 = 7, SJumpReg = 8, SLui = 9, SLli = 10, SLtr = 11, SCtr = 12;
    localparam int SLw1 = 13, SLw2 = 14, SSw = 15, SSyscall = 16, STrap = 17, SIrq = 18;

    typedef struct {
        int st;
        bit mr;
        bit irq;
        int op;
        int cause;
    } cyc_t;

    logic CLK;
    logic Reset;
    int   nTests;
    int   nFail;
    bit   chkEn;
    cyc_t cur;
    cyc_t q[$];

    mc_control_fsm_if #(.OPCODE_W(4), .STATE_W(5), .CAUSE_W(2)) ifc ();

    mc_control_fsm #(
        .OPCODE_W    (4),
        .STATE_W     (5),
        .CAUSE_W     (2),
        .MEM_TIMEOUT (TO)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (ifc.master)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input int act, input int exp);
        nTests++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit irqBit(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic pushC(input int st, input bit mr, input int irqMode, input int op,
                         input int cause);
        cyc_t e;
        e.st    = st;
        e.mr    = mr;
        e.irq   = irqBit(irqMode);
        e.op    = (st == SDecode) ? op : int'($urandom_range(0, 15));
        e.cause = cause;
        q.push_back(e);
    endtask

    // A memory access: 'stall' not-ready cycles, then ready, unless the timeout fires first.
    task automatic memPhase(input int st, input int stall, input int irqMode, output bit ok);
        int n;
        n = (stall > TO) ? TO + 1 : stall;
        for (int i = 0; i < n; i++) pushC(st, 1'b0, irqMode, 0, 0);
        if (stall > TO) begin
            pushC(STrap, 1'($urandom_range(0, 1)), irqMode, 0, 2);
            ok = 1'b0;
        end else begin
            pushC(st, 1'b1, irqMode, 0, 0);
            ok = 1'b1;
        end
    endtask

    task automatic genInstr(input int op, input int fStall, input int mStall, input int irqMode);
        bit ok;
        bit r;
        r = 1'($urandom_range(0, 1));
        memPhase(SFetch, fStall, irqMode, ok);
        if (!ok) return;
        pushC(SDecode, r, irqMode, op, 0);
        case (op)
            0: begin
                pushC(SCExec, r, irqMode, 0, 0);
                pushC(SCWrite, r, irqMode, 0, 0);
            end
            1, 2: pushC(SBranch, r, irqMode, 0, 0);
            3:    pushC(SJump, r, irqMode, 0, 0);
            4: begin
                pushC(SJal1, r, irqMode, 0, 0);
                pushC(SJal2, r, irqMode, 0, 0);
            end
            5:  pushC(SJumpReg, r, irqMode, 0, 0);
            6:  pushC(SLui, r, irqMode, 0, 0);
            7:  pushC(SLli, r, irqMode, 0, 0);
            8:  pushC(SLtr, r, irqMode, 0, 0);
            9:  pushC(SCtr, r, irqMode, 0, 0);
            10: begin
                memPhase(SLw1, mStall, irqMode, ok);
                if (!ok) return;
                pushC(SLw2, r, irqMode, 0, 0);
            end
            11: begin
                memPhase(SSw, mStall, irqMode, ok);
                if (!ok) return;
            end
            12: pushC(SSyscall, r, irqMode, 0, 0);
            13: begin
                pushC(STrap, r, irqMode, 0, 0);
                return;
            end
            default: begin
                pushC(STrap, r, irqMode, 0, 1);
                return;
            end
        endcase
`ifdef CTRL_IRQ_EN
        if (q[$].irq) pushC(SIrq, r, 2, 0, 3);
`endif
    endtask

    task automatic runTrace(input int n);
        cyc_t e;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            e            = q.pop_front();
            ifc.MemReady = e.mr;
            ifc.IrqReq   = e.irq;
            ifc.Opcode   = e.op[3:0];
            cur          = e;
            chkEn        = 1'b1;
            @(posedge CLK);
            #1;
        end
        chkEn = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (chkEn) begin
            int  st;
            bit  fr;
            bit  pcw;
            int  src;
            st  = cur.st;
            fr  = (st == SFetch) && cur.mr;
            pcw = fr || (st inside {SJump, SJal2, SJumpReg, SSyscall, STrap, SIrq});
            check("state", int'(ifc.current_state), st);
            check("PCWrite", int'(ifc.PCWrite), int'(pcw));
            check("IRWrite", int'(ifc.IRWrite), int'(fr));
            check("MemRead", int'(ifc.MemRead), int'(st inside {SFetch, SLw1}));
            check("MemWrite", int'(ifc.MemWrite), int'(st == SSw));
            check("RegWrite", int'(ifc.RegWrite),
                  int'(st inside {SCWrite, SJal1, SLui, SLli, SLtr, SLw2}));
            check("CRWrite", int'(ifc.CRWrite), int'(st inside {SCWrite, SCtr}));
            check("isBranch", int'(ifc.isBranch), int'(st == SBranch));
            check("EPCWrite", int'(ifc.EPCWrite), int'(st inside {STrap, SIrq}));
            check("CauseWrite", int'(ifc.CauseWrite), int'(st inside {STrap, SIrq}));
            check("IrqAck", int'(ifc.IrqAck), int'(st == SIrq));
            if (pcw) begin
                src = (st inside {STrap, SIrq}) ? 4 : (st inside {SJump, SJal2}) ? 3 :
                      (st == SJumpReg) ? 2 : 0;
                check("PCSrc", int'(ifc.PCSrc), src);
            end
            if (st inside {STrap, SIrq}) check("IntCause", int'(ifc.IntCause), cur.cause);
        end
    end

    initial begin
        int expIrqLen;
        nTests       = 0;
        nFail        = 0;
        chkEn        = 1'b0;
        Reset        = 1'b1;
        ifc.MemReady = 1'b1;
        ifc.IrqReq   = 1'b1;
        ifc.Opcode   = 4'd0;
        #3;
        check("rst_state", int'(ifc.current_state), SFetch);
        check("rst_MemRead", int'(ifc.MemRead), 0);
        check("rst_IRWrite", int'(ifc.IRWrite), 0);
        check("rst_PCWrite", int'(ifc.PCWrite), 0);
        check("rst_IrqAck", int'(ifc.IrqAck), 0);
        check("rst_IntCause", int'(ifc.IntCause), 0);
        check("rst_PCSrc", int'(ifc.PCSrc), 0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        Reset = 1'b0;

        // ADD with no stalls: four cycles.
        genInstr(0, 0, 0, 0);
        check("len_add", q.size(), 4);
        runTrace(q.size());
        // Fetch stalled three cycles.
        genInstr(0, 3, 0, 0);
        check("len_fetch_stall", q.size(), 7);
        runTrace(q.size());
        // Load timing out after sixteen stalled cycles.
        genInstr(10, 0, 16, 0);
        check("len_lw_timeout", q.size(), 19);
        runTrace(q.size());
        check("buserr_cause_held", int'(ifc.IntCause), 2);
        // Ready on the timeout cycle wins.
        genInstr(10, 0, 15, 0);
        check("len_lw_boundary", q.size(), 19);
        runTrace(q.size());
        genInstr(11, 16, 0, 0);
        runTrace(q.size());
        genInstr(11, 0, 16, 0);
        runTrace(q.size());
        genInstr(14, 0, 0, 0);
        check("len_illegal", q.size(), 3);
        runTrace(q.size());
        check("illegal_cause_held", int'(ifc.IntCause), 1);
        genInstr(13, 0, 0, 0);
        runTrace(q.size());
        check("trap_cause_held", int'(ifc.IntCause), 0);
        genInstr(12, 0, 0, 0);
        check("len_syscall", q.size(), 3);
        runTrace(q.size());
        // Interrupt held high through an ADD.
`ifdef CTRL_IRQ_EN
        expIrqLen = 5;
`else
        expIrqLen = 4;
`endif
        genInstr(0, 0, 0, 1);
        check("len_add_irq", q.size(), expIrqLen);
        runTrace(q.size());

        // Reset while LW1 is stalled.
        genInstr(10, 0, 20, 0);
        runTrace(7);
        q.delete();
        ifc.MemReady = 1'b1;
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst_state", int'(ifc.current_state), SFetch);
        check("mid_rst_MemRead", int'(ifc.MemRead), 0);
        check("mid_rst_MemWrite", int'(ifc.MemWrite), 0);
        @(posedge CLK);
        #1;
        check("mid_rst_IRWrite", int'(ifc.IRWrite), 0);
        Reset = 1'b0;
        genInstr(0, 0, 0, 0);
        runTrace(q.size());

        // Reset during a FETCH stall must clear the wait counter.
        genInstr(0, 30, 0, 0);
        runTrace(11);
        q.delete();
        #2;
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        genInstr(0, 15, 0, 0);
        runTrace(q.size());

        for (int i = 0; i < 300; i++) begin
            int op;
            int fs;
            int ms;
            op = int'($urandom_range(0, 15));
            fs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 17)) : 0;
            ms = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 18))
                                             : int'($urandom_range(0, 2));
            genInstr(op, fs, ms, ($urandom_range(0, 1) == 1) ? 2 : 0);
            runTrace(q.size());
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
